ber_test_sequencer: RTL and testbench

Run controller for the 64-bit PRBS7 loopback bit-error test on the GT receive side. On a start command it resets the frame aligner, waits for alignment with a timeout, and discards a settle interval. It then accumulates the aligner's per-word error count over a programmed window of words and latches the totals and a result code for the control-interface status registers. It runs in the `gt0_rxusrclk2` domain; register-side command and config signals are synchronised before they reach this block.

---
 rtl/ber_test_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ber_test_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_test_sequencer.sv
// ber_test_sequencer: run controller for the 64-bit PRBS7 loopback bit-error test.
// Sequences aligner reset, lock wait with timeout, settle discard and the measurement
// window, then latches word/error totals and a result code.
// Compile-time option: define BER_SEQ_SAT_EN to make the accumulators saturate at
// all-ones instead of wrapping.
module ber_test_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned ALIGN_TIMEOUT = 65536,
  parameter int unsigned SETTLE_WORDS  = 64,
  parameter int unsigned CNT_W         = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      window_words,
  input  logic [15:0]      mask_cfg,
  input  logic             aligned,
  input  logic [6:0]       error_count,
  output logic             align_reset,
  output logic [15:0]      mask,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] words_tested,
  output logic [CNT_W-1:0] errors_total,
  output logic [1:0]       fail_code
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRst       = 3'd1,
    StWaitAlign = 3'd2,
    StSettle    = 3'd3,
    StMeasure   = 3'd4,
    StDone      = 3'd5
  } state_e;

  localparam logic [1:0] FailNone    = 2'd0;
  localparam logic [1:0] FailTimeout = 2'd1;
  localparam logic [1:0] FailLock    = 2'd2;
  localparam logic [1:0] FailAbort   = 2'd3;

  // Window compare is done at the wider of the accumulator and window widths.
  localparam int unsigned CmpW = (CNT_W > 32) ? CNT_W : 32;

  state_e           state_q;
  logic             align_reset_q;
  logic [15:0]      mask_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       fail_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] errors_q;
  logic [31:0]      phase_cnt_q;  // RST hold count, then SETTLE good-word count
  logic [31:0]      to_cnt_q;     // WAIT_ALIGN cycles spent this run

  logic [6:0]       err_clip;
  logic [CNT_W-1:0] words_nxt;
  logic [CNT_W-1:0] errors_nxt;
  logic             window_hit;

`ifdef BER_SEQ_SAT_EN
  localparam int unsigned SumW = ((CNT_W > 7) ? CNT_W : 7) + 1;
  logic [SumW-1:0] err_sum;
`endif

  // Next accumulator values for one measured word and the window-complete test.
  always_comb begin
    // A word can hold at most 64 bit errors; larger counts are aligner glitches.
    err_clip = (error_count > 7'd64) ? 7'd64 : error_count;
`ifdef BER_SEQ_SAT_EN
    err_sum    = SumW'(errors_q) + SumW'(err_clip);
    words_nxt  = (&words_q) ? words_q : words_q + CNT_W'(1);
    errors_nxt = (err_sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
`else
    words_nxt  = words_q + CNT_W'(1);
    errors_nxt = errors_q + CNT_W'(err_clip);
`endif
    window_hit = (window_words != 32'd0) && (CmpW'(words_nxt) == CmpW'(window_words));
  end

  // Run sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      align_reset_q <= 1'b0;
      mask_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= FailNone;
      words_q       <= '0;
      errors_q      <= '0;
      phase_cnt_q   <= '0;
      to_cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StRst;
            align_reset_q <= 1'b1;
            busy_q        <= 1'b1;
            mask_q        <= mask_cfg;
            fail_q        <= FailNone;
            words_q       <= '0;
            errors_q      <= '0;
            phase_cnt_q   <= '0;
            to_cnt_q      <= '0;
          end
        end
        StRst: begin
          if (abort) begin
            state_q       <= StDone;
            align_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            fail_q        <= FailAbort;
          end else if (phase_cnt_q == RST_CYCLES - 1) begin
            state_q       <= StWaitAlign;
            align_reset_q <= 1'b0;
            phase_cnt_q   <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q + 32'd1;
          end
        end
        StWaitAlign: begin
          if (abort) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= FailAbort;
          end else if (aligned) begin
            state_q     <= StSettle;
            phase_cnt_q <= '0;
          end else if (to_cnt_q == ALIGN_TIMEOUT - 1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= FailTimeout;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        StSettle: begin
          if (abort) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= FailAbort;
          end else if (!aligned) begin
            // Timeout budget is shared across re-lock attempts, so to_cnt_q is kept.
            state_q     <= StWaitAlign;
            phase_cnt_q <= '0;
          end else if (phase_cnt_q == SETTLE_WORDS - 1) begin
            state_q     <= StMeasure;
            phase_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q + 32'd1;
          end
        end
        StMeasure: begin
          if (abort) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= FailAbort;
          end else if (!aligned) begin
            // The word seen in the loss cycle is not trusted and is not counted.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= FailLock;
          end else begin
            words_q  <= words_nxt;
            errors_q <= errors_nxt;
            if (window_hit) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              fail_q  <= FailNone;
            end
          end
        end
        default: begin
          state_q       <= StIdle;
          align_reset_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign align_reset  = align_reset_q;
  assign mask         = mask_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail_code    = fail_q;
  assign words_tested = words_q;
  assign errors_total = errors_q;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// tb_ber_test_sequencer: directed checks of ber_test_sequencer with default parameters,
// plus a small-parameter instance for the accumulator width limit and a short timeout.
module tb_ber_test_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] window_words;
  logic [15:0] mask_cfg;
  logic        aligned;
  logic [6:0]  error_count;
  logic        align_reset;
  logic [15:0] mask;
  logic        busy;
  logic        done;
  logic [2:0]  state;
  logic [47:0] words_tested;
  logic [47:0] errors_total;
  logic [1:0]  fail_code;

  // Small instance signals.
  logic        s_start;
  logic        s_abort;
  logic [31:0] s_window;
  logic [15:0] s_mask_cfg;
  logic        s_aligned;
  logic [6:0]  s_err;
  logic        s_align_reset;
  logic [15:0] s_mask;
  logic        s_busy;
  logic        s_done;
  logic [2:0]  s_state;
  logic [3:0]  s_words;
  logic [3:0]  s_errors;
  logic [1:0]  s_fail;

  int n_cmp = 0;
  int n_bad = 0;

  ber_test_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .window_words (window_words),
    .mask_cfg     (mask_cfg),
    .aligned      (aligned),
    .error_count  (error_count),
    .align_reset  (align_reset),
    .mask         (mask),
    .busy         (busy),
    .done         (done),
    .state        (state),
    .words_tested (words_tested),
    .errors_total (errors_total),
    .fail_code    (fail_code)
  );

  ber_test_sequencer #(
    .RST_CYCLES    (2),
    .ALIGN_TIMEOUT (8),
    .SETTLE_WORDS  (2),
    .CNT_W         (4)
  ) dut_s (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (s_start),
    .abort        (s_abort),
    .window_words (s_window),
    .mask_cfg     (s_mask_cfg),
    .aligned      (s_aligned),
    .error_count  (s_err),
    .align_reset  (s_align_reset),
    .mask         (s_mask),
    .busy         (s_busy),
    .done         (s_done),
    .state        (s_state),
    .words_tested (s_words),
    .errors_total (s_errors),
    .fail_code    (s_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic kick_s();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
    int n = 0;
    while (state !== st && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(state), 64'(st));
  endtask

  // Called right after kick(); cyc counts rising edges from the one sampling start.
  task automatic wait_done(input int limit, input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int cyc;
    int rst_hi;
    logic [3:0] exp_a;
    logic [3:0] exp_b;

    reset_n      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    window_words = 32'd0;
    mask_cfg     = 16'h0000;
    aligned      = 1'b0;
    error_count  = 7'd0;
    s_start      = 1'b0;
    s_abort      = 1'b0;
    s_window     = 32'd0;
    s_mask_cfg   = 16'h0000;
    s_aligned    = 1'b0;
    s_err        = 7'd0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_align_reset", 64'(align_reset), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_words", 64'(words_tested), 64'd0);
    check_eq("rst_errors", 64'(errors_total), 64'd0);
    check_eq("rst_fail", 64'(fail_code), 64'd0);
    check_eq("rst_mask", 64'(mask), 64'd0);

    // Fault-free run of 1000 words, checking RST length and total latency.
    aligned      = 1'b1;
    window_words = 32'd1000;
    mask_cfg     = 16'hA5C3;
    kick();
    cyc = 1;
    check_eq("t1_align_reset_rise", 64'(align_reset), 64'd1);
    check_eq("t1_state_rst", 64'(state), 64'd1);
    check_eq("t1_busy", 64'(busy), 64'd1);
    check_eq("t1_mask", 64'(mask), 64'hA5C3);
    rst_hi = 0;
    while (align_reset && rst_hi < 100) begin
      rst_hi++;
      @(negedge clk);
      cyc++;
    end
    check_eq("t1_rst_len", 64'(rst_hi), 64'd16);
    check_eq("t1_state_wait", 64'(state), 64'd2);
    mask_cfg = 16'h1234;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t1_latency", 64'(cyc), 64'd1082);
    check_eq("t1_words", 64'(words_tested), 64'd1000);
    check_eq("t1_errors", 64'(errors_total), 64'd0);
    check_eq("t1_fail", 64'(fail_code), 64'd0);
    check_eq("t1_state_done", 64'(state), 64'd5);
    check_eq("t1_busy_done", 64'(busy), 64'd0);
    check_eq("t1_mask_held", 64'(mask), 64'hA5C3);
    @(negedge clk);
    check_eq("t1_done_pulse", 64'(done), 64'd0);
    check_eq("t1_words_hold", 64'(words_tested), 64'd1000);

    // Three errors every word over 100 words.
    window_words = 32'd100;
    error_count  = 7'd3;
    kick();
    wait_done(500, "t2_done_seen", cyc);
    check_eq("t2_latency", 64'(cyc), 64'd182);
    check_eq("t2_errors", 64'(errors_total), 64'd300);
    check_eq("t2_words", 64'(words_tested), 64'd100);

    // One word reports 127 errors, clipped to 64.
    kick();
    wait_state(3'd4, 200, "t2b_measure");
    error_count = 7'd127;
    @(negedge clk);
    error_count = 7'd3;
    wait_done(500, "t2b_done_seen", cyc);
    check_eq("t2b_errors", 64'(errors_total), 64'd361);
    check_eq("t2b_words", 64'(words_tested), 64'd100);

    // No lock: timeout after RST plus the full WAIT_ALIGN budget.
    aligned = 1'b0;
    kick();
    wait_done(70000, "t3_done_seen", cyc);
    check_eq("t3_latency", 64'(cyc), 64'd65553);
    check_eq("t3_fail", 64'(fail_code), 64'd1);
    check_eq("t3_words", 64'(words_tested), 64'd0);

    // Lock lost after 50 measured words.
    aligned      = 1'b1;
    window_words = 32'd0;
    error_count  = 7'd2;
    kick();
    wait_state(3'd4, 200, "t4_measure");
    repeat (50) @(negedge clk);
    check_eq("t4_words_pre", 64'(words_tested), 64'd50);
    check_eq("t4_errors_pre", 64'(errors_total), 64'd100);
    aligned = 1'b0;
    @(negedge clk);
    aligned = 1'b1;
    check_eq("t4_state", 64'(state), 64'd5);
    check_eq("t4_fail", 64'(fail_code), 64'd2);
    check_eq("t4_words", 64'(words_tested), 64'd50);
    check_eq("t4_done", 64'(done), 64'd1);

    // Lock drop during SETTLE returns to WAIT_ALIGN, then the run completes.
    window_words = 32'd20;
    error_count  = 7'd1;
    kick();
    wait_state(3'd3, 200, "t4b_settle");
    repeat (10) @(negedge clk);
    aligned = 1'b0;
    @(negedge clk);
    check_eq("t4b_back_to_wait", 64'(state), 64'd2);
    aligned = 1'b1;
    wait_done(500, "t4b_done_seen", cyc);
    check_eq("t4b_fail", 64'(fail_code), 64'd0);
    check_eq("t4b_words", 64'(words_tested), 64'd20);
    check_eq("t4b_errors", 64'(errors_total), 64'd20);

    // Abort and lock loss together: abort wins, accumulators hold.
    window_words = 32'd0;
    kick();
    wait_state(3'd4, 200, "t5_measure");
    repeat (5) @(negedge clk);
    abort   = 1'b1;
    aligned = 1'b0;
    @(negedge clk);
    abort   = 1'b0;
    aligned = 1'b1;
    check_eq("t5_state", 64'(state), 64'd5);
    check_eq("t5_fail", 64'(fail_code), 64'd3);
    check_eq("t5_done", 64'(done), 64'd1);
    check_eq("t5_words", 64'(words_tested), 64'd5);
    check_eq("t5_errors", 64'(errors_total), 64'd5);

    // Abort during RST drops align_reset.
    kick();
    check_eq("t5b_align_reset", 64'(align_reset), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5b_state", 64'(state), 64'd5);
    check_eq("t5b_align_reset_low", 64'(align_reset), 64'd0);
    check_eq("t5b_fail", 64'(fail_code), 64'd3);

    // Start while busy is ignored; then reset mid-run.
    kick();
    wait_state(3'd4, 200, "t5c_measure");
    repeat (3) @(negedge clk);
    kick();
    check_eq("t5c_state", 64'(state), 64'd4);
    check_eq("t5c_words", 64'(words_tested), 64'd4);
    check_eq("t5c_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t5c_rst_state", 64'(state), 64'd0);
    check_eq("t5c_rst_words", 64'(words_tested), 64'd0);
    check_eq("t5c_rst_errors", 64'(errors_total), 64'd0);
    check_eq("t5c_rst_busy", 64'(busy), 64'd0);
    check_eq("t5c_rst_mask", 64'(mask), 64'd0);
    check_eq("t5c_rst_fail", 64'(fail_code), 64'd0);
    @(negedge clk);
    check_eq("t5c_rst_no_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t5c_post_done", 64'(done), 64'd0);
    check_eq("t5c_post_state", 64'(state), 64'd0);

    // Small instance: timeout of 8 after 2 RST cycles.
    s_mask_cfg = 16'h00C3;
    kick_s();
    cyc = 1;
    while (!s_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_to_latency", 64'(cyc), 64'd11);
    check_eq("t6_to_fail", 64'(s_fail), 64'd1);
    check_eq("t6_to_busy", 64'(s_busy), 64'd0);
    check_eq("t6_to_align_reset", 64'(s_align_reset), 64'd0);
    check_eq("t6_to_mask", 64'(s_mask), 64'h00C3);

    // Small instance: 4-bit accumulator at its limit.
`ifdef BER_SEQ_SAT_EN
    exp_a = 4'd15;
    exp_b = 4'd15;
`else
    exp_a = 4'd3;
    exp_b = 4'd8;
`endif
    s_aligned = 1'b1;
    s_err     = 7'd7;
    kick_s();
    cyc = 0;
    while (s_state !== 3'd4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_measure", 64'(s_state), 64'd4);
    repeat (2) @(negedge clk);
    check_eq("t6_errors_14", 64'(s_errors), 64'd14);
    s_err = 7'd5;
    @(negedge clk);
    check_eq("t6_errors_limit", 64'(s_errors), 64'(exp_a));
    @(negedge clk);
    check_eq("t6_errors_after", 64'(s_errors), 64'(exp_b));
    check_eq("t6_words", 64'(s_words), 64'd4);
    s_abort = 1'b1;
    @(negedge clk);
    s_abort = 1'b0;
    check_eq("t6_abort_fail", 64'(s_fail), 64'd3);
    check_eq("t6_abort_hold", 64'(s_errors), 64'(exp_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
